// File: rtl/switch_pkg.sv
// Shared switch definitions: default bus widths, arbiter FSM states and the
// width of the optional per-requester beat counters.
package switch_pkg;

  localparam int unsigned DEF_ADDR_WIDTH = 8;
  localparam int unsigned DEF_DATA_WIDTH = 16;
  localparam int unsigned STAT_W         = 16;

  typedef enum logic {ARB_IDLE, ARB_OWN} arb_state_e;

endpackage

// File: rtl/switch_input_arbiter_if.sv
// Requester-side handshake and switch-side beat bus of the input arbiter.
// Ports (signals):
//   req_vld/req_addr/req_data  requester valid and flattened payloads
//   req_rdy                    per-requester ready (one-hot or zero)
//   vld/addr/data/grant_id     registered beat presented to the switch
// Modports: slave = arbiter view, master = requesters/switch view.
interface switch_input_arbiter_if #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 16
);
  localparam int unsigned ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]            req_vld;
  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]            req_rdy;
  logic                          vld;
  logic [ADDR_WIDTH-1:0]         addr;
  logic [DATA_WIDTH-1:0]         data;
  logic [ID_W-1:0]               grant_id;

  modport slave (
    input  req_vld, req_addr, req_data,
    output req_rdy, vld, addr, data, grant_id
  );

  modport master (
    output req_vld, req_addr, req_data,
    input  req_rdy, vld, addr, data, grant_id
  );
endinterface

// File: rtl/switch_rr_pick.sv
// Rotating-priority search: first valid requester starting at rr_ptr.
// Ports:
//   req_vld  in   per-requester valid
//   rr_ptr   in   highest-priority index this cycle
//   found    out  some requester is valid
//   idx      out  index of the winner (0 when none found)
module switch_rr_pick #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned ID_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_vld,
  input  logic [ID_W-1:0]    rr_ptr,
  output logic               found,
  output logic [ID_W-1:0]    idx
);

  int unsigned j;

  // Scan rr_ptr, rr_ptr+1, ... wrapping at NUM_REQ; the first hit wins.
  always_comb begin : pick
    found = 1'b0;
    idx   = '0;
    j     = 0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      j = 32'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && req_vld[ID_W'(j)]) begin
        found = 1'b1;
        idx   = ID_W'(j);
      end
    end
  end

endmodule

// File: rtl/switch_input_arbiter.sv
// Round-robin arbiter with bounded burst lock feeding the switch input.
// The winning beat is registered onto vld/addr/data/grant_id one cycle after
// its handshake; vld is a pure strobe because the switch never stalls.
// Ports:
//   clk, rstn   clock, async active-low reset
//   en          1 = grants allowed, 0 = no new grants
//   bus         switch_input_arbiter_if.slave (requester handshake + beat out)
//   stat_cnt    per-requester saturating accepted-beat counts (ARB_STATS_EN only)
// Optional feature macro: ARB_STATS_EN.
module switch_input_arbiter
  import switch_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
`ifdef ARB_STATS_EN
  output logic [NUM_REQ*STAT_W-1:0] stat_cnt,
`endif
  switch_input_arbiter_if.slave bus
);

  localparam int unsigned ID_W = $clog2(NUM_REQ);
  localparam int unsigned BC_W = $clog2(MAX_BURST + 1);

  arb_state_e            state, state_nxt;
  logic [ID_W-1:0]       owner, owner_nxt;
  logic [ID_W-1:0]       rr_ptr, rr_nxt;
  logic [BC_W-1:0]       burst_cnt, burst_nxt;
  logic [ID_W-1:0]       pick_idx, cand;
  logic                  pick_found, lock, cand_ok;
  logic [NUM_REQ-1:0]    rdy;

  logic                  vld_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic [ID_W-1:0]       grant_q;

  logic [ADDR_WIDTH-1:0] addr_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];

  // Unflatten requester payloads.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g] = bus.req_addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign data_arr[g] = bus.req_data[g*DATA_WIDTH +: DATA_WIDTH];
  end

  switch_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
    .req_vld (bus.req_vld),
    .rr_ptr  (rr_ptr),
    .found   (pick_found),
    .idx     (pick_idx)
  );

  // Candidate selection and next-state. The owner keeps the grant while it
  // stays valid and has burst budget; otherwise round-robin from rr_ptr.
  // On burst expiry a re-selected owner starts a fresh burst at 1.
  always_comb begin : arb_comb
    state_nxt = ARB_IDLE;
    owner_nxt = owner;
    rr_nxt    = rr_ptr;
    burst_nxt = '0;
    rdy       = '0;
    lock      = en && (state == ARB_OWN) && bus.req_vld[owner]
                && (burst_cnt < BC_W'(MAX_BURST));
    cand      = lock ? owner : pick_idx;
    // rdy is forced low while reset is asserted.
    cand_ok   = rstn && en && (lock || pick_found);
    if (cand_ok) begin
      rdy[cand] = 1'b1;
      state_nxt = ARB_OWN;
      owner_nxt = cand;
      rr_nxt    = (cand == ID_W'(NUM_REQ - 1)) ? '0 : cand + ID_W'(1);
      burst_nxt = lock ? burst_cnt + BC_W'(1) : BC_W'(1);
    end
  end

  // Arbitration state register.
  always_ff @(posedge clk or negedge rstn) begin : arb_state
    if (!rstn) begin
      state     <= ARB_IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_nxt;
      burst_cnt <= burst_nxt;
    end
  end

  // Registered beat toward the switch; payload holds when idle.
  always_ff @(posedge clk or negedge rstn) begin : beat_reg
    if (!rstn) begin
      vld_q   <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      grant_q <= '0;
    end else begin
      vld_q <= cand_ok;
      if (cand_ok) begin
        addr_q  <= addr_arr[cand];
        data_q  <= data_arr[cand];
        grant_q <= cand;
      end
    end
  end

  assign bus.req_rdy  = rdy;
  assign bus.vld      = vld_q;
  assign bus.addr     = addr_q;
  assign bus.data     = data_q;
  assign bus.grant_id = grant_q;

`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] stat_q [NUM_REQ];

  // Saturating accepted-beat counters, updated alongside vld.
  always_ff @(posedge clk or negedge rstn) begin : stats
    if (!rstn) begin
      for (int i = 0; i < NUM_REQ; i++) stat_q[i] <= '0;
    end else if (cand_ok && (stat_q[cand] != '1)) begin
      stat_q[cand] <= stat_q[cand] + STAT_W'(1);
    end
  end

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_stat
    assign stat_cnt[g*STAT_W +: STAT_W] = stat_q[g];
  end
`endif

endmodule

// File: tb/tb_switch_input_arbiter.sv
// Bench for switch_input_arbiter: two instances (MAX_BURST 4 and 1) share one
// stimulus; a per-cycle model checks both, and directed literals pin key
// grant sequences. Build with ARB_STATS_EN to also exercise stat_cnt.
module tb_switch_input_arbiter;

  localparam int N  = 4;
  localparam int AW = 8;
  localparam int DW = 16;
  localparam int MB [2] = '{4, 1};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rstn, en;
  logic [N-1:0]    t_vld;
  logic [N*AW-1:0] t_addr;
  logic [N*DW-1:0] t_data;

  switch_input_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus0 ();
  switch_input_arbiter_if #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus1 ();

  assign bus0.req_vld  = t_vld;
  assign bus0.req_addr = t_addr;
  assign bus0.req_data = t_data;
  assign bus1.req_vld  = t_vld;
  assign bus1.req_addr = t_addr;
  assign bus1.req_data = t_data;

`ifdef ARB_STATS_EN
  logic [N*16-1:0] st0, st1;
  logic [N*16-1:0] o_stat [2];
  assign o_stat[0] = st0;
  assign o_stat[1] = st1;
`endif

  switch_input_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(4)) dut0 (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
`ifdef ARB_STATS_EN
    .stat_cnt (st0),
`endif
    .bus  (bus0)
  );

  switch_input_arbiter #(.NUM_REQ(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(1)) dut1 (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
`ifdef ARB_STATS_EN
    .stat_cnt (st1),
`endif
    .bus  (bus1)
  );

  logic          o_vld  [2];
  logic [AW-1:0] o_addr [2];
  logic [DW-1:0] o_data [2];
  logic [1:0]    o_gid  [2];
  logic [N-1:0]  o_rdy  [2];
  assign o_vld[0]  = bus0.vld;      assign o_vld[1]  = bus1.vld;
  assign o_addr[0] = bus0.addr;     assign o_addr[1] = bus1.addr;
  assign o_data[0] = bus0.data;     assign o_data[1] = bus1.data;
  assign o_gid[0]  = bus0.grant_id; assign o_gid[1]  = bus1.grant_id;
  assign o_rdy[0]  = bus0.req_rdy;  assign o_rdy[1]  = bus1.req_rdy;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Model: expected registered beat, last winner, current run length.
  logic          m_vld  [2];
  logic [AW-1:0] m_addr [2];
  logic [DW-1:0] m_data [2];
  int            m_gid  [2];
  int            m_last [2];
  int            m_run  [2];
  int            m_stat [2][N];

  int glog0[$], glog1[$];
  logic [AW-1:0] alog0[$];

  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      int c;
      bit lk;
      int j;
      logic [N-1:0] er;
      if (!rstn) begin
        chk("rst_vld",  64'(o_vld[k]),  64'd0);
        chk("rst_addr", 64'(o_addr[k]), 64'd0);
        chk("rst_data", 64'(o_data[k]), 64'd0);
        chk("rst_gid",  64'(o_gid[k]),  64'd0);
        chk("rst_rdy",  64'(o_rdy[k]),  64'd0);
        m_vld[k] = 1'b0; m_addr[k] = '0; m_data[k] = '0; m_gid[k] = 0;
        m_last[k] = N - 1; m_run[k] = 0;
        for (int r = 0; r < N; r++) m_stat[k][r] = 0;
      end else begin
        chk("vld",  64'(o_vld[k]),  64'(m_vld[k]));
        chk("addr", 64'(o_addr[k]), 64'(m_addr[k]));
        chk("data", 64'(o_data[k]), 64'(m_data[k]));
        chk("gid",  64'(o_gid[k]),  64'(m_gid[k]));
`ifdef ARB_STATS_EN
        for (int r = 0; r < N; r++)
          chk("stat", 64'(o_stat[k][r*16 +: 16]), 64'(m_stat[k][r]));
`endif
        if (o_vld[k]) begin
          if (k == 0) begin glog0.push_back(int'(o_gid[0])); alog0.push_back(o_addr[0]); end
          else glog1.push_back(int'(o_gid[1]));
        end
        c = -1;
        lk = 1'b0;
        if (en) begin
          if (m_run[k] > 0 && t_vld[m_last[k]] && m_run[k] < MB[k]) begin
            c = m_last[k];
            lk = 1'b1;
          end else begin
            for (int i = 0; i < N; i++) begin
              j = (m_last[k] + 1 + i) % N;
              if (c < 0 && t_vld[j]) c = j;
            end
          end
        end
        er = '0;
        if (c >= 0) er[c] = 1'b1;
        chk("rdy", 64'(o_rdy[k]), 64'(er));
        if (c >= 0) begin
          m_vld[k]  = 1'b1;
          m_addr[k] = t_addr[c*AW +: AW];
          m_data[k] = t_data[c*DW +: DW];
          m_gid[k]  = c;
          m_run[k]  = lk ? m_run[k] + 1 : 1;
          m_last[k] = c;
          if (m_stat[k][c] < 16'hFFFF) m_stat[k][c] = m_stat[k][c] + 1;
        end else begin
          m_vld[k] = 1'b0;
          m_run[k] = 0;
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) t_data[i*DW +: DW] = 16'($urandom);
    end
  endtask

  task automatic clear_logs();
    glog0.delete();
    glog1.delete();
    alog0.delete();
  endtask

  task automatic chk_seq(input string nm, input int k, input int exp [], input int first);
    int sz;
    sz = (k == 0) ? glog0.size() : glog1.size();
    chk({nm, "_len"}, 64'(sz >= first + exp.size()), 64'd1);
    if (sz >= first + exp.size())
      for (int i = 0; i < exp.size(); i++)
        chk(nm, 64'((k == 0) ? glog0[first+i] : glog1[first+i]), 64'(exp[i]));
  endtask

  initial begin
    int e_a0 [], e_a1 [], e_b0 [], e_b1 [];
    rstn = 1'b0;
    en   = 1'b0;
    t_vld = '0;
    t_data = '0;
    for (int i = 0; i < N; i++) t_addr[i*AW +: AW] = 8'(8'h10 + i);
    tick(3);

    // All valid after reset: first grant 0; burst-4 vs pure round-robin.
    rstn = 1'b1; en = 1'b1; t_vld = 4'hF;
    clear_logs();
    tick(13);
    e_a0 = '{0,0,0,0,1,1,1,1,2,2,2,2};
    e_a1 = '{0,1,2,3,0,1,2,3,0,1,2,3};
    chk_seq("seq_mb4", 0, e_a0, 0);
    chk_seq("seq_mb1", 1, e_a1, 0);

    // Asynchronous reset mid-burst clears outputs immediately.
    #2 rstn = 1'b0;
    #1;
    for (int k = 0; k < 2; k++) begin
      chk("async_vld",  64'(o_vld[k]),  64'd0);
      chk("async_addr", 64'(o_addr[k]), 64'd0);
      chk("async_data", 64'(o_data[k]), 64'd0);
      chk("async_gid",  64'(o_gid[k]),  64'd0);
      chk("async_rdy",  64'(o_rdy[k]),  64'd0);
    end
    tick(2);

    // Restart at req 0, then req 1 drops after two beats.
    rstn = 1'b1;
    clear_logs();
    tick(6);
    t_vld = 4'b1101;
    tick(5);
    e_b0 = '{0,0,0,0,1,1,2,2};
    e_b1 = '{0,1,2,3,0,1,2,3,0,2};
    chk_seq("drop_mb4", 0, e_b0, 0);
    chk_seq("drop_mb1", 1, e_b1, 0);

    // Lone requester 2 for six beats; burst expiry does not bubble.
    t_vld = '0;
    tick(2);
    clear_logs();
    t_addr[2*AW +: AW] = 8'h3F;
    t_vld = 4'b0100;
    tick(6);
    t_vld = '0;
    tick(3);
    chk("solo_len0", 64'(glog0.size()), 64'd6);
    chk("solo_len1", 64'(glog1.size()), 64'd6);
    foreach (glog0[i]) chk("solo_gid", 64'(glog0[i]), 64'd2);
    foreach (alog0[i]) chk("solo_addr", 64'(alog0[i]), 64'h3F);

    // en low for five cycles with reqs 1 and 3 valid.
    t_vld = 4'b1010;
    tick(3);
    en = 1'b0;
    clear_logs();
    @(negedge clk); #1;
    chk("inflight0", 64'(o_vld[0]), 64'd1);
    chk("inflight1", 64'(o_vld[1]), 64'd1);
    repeat (4) begin
      @(negedge clk); #1;
      for (int k = 0; k < 2; k++) begin
        chk("en0_vld", 64'(o_vld[k]), 64'd0);
        chk("en0_rdy", 64'(o_rdy[k]), 64'd0);
      end
    end
    tick(1);
    en = 1'b1;
    tick(4);
    chk_seq("resume0", 0, '{3,1}, 0);
    chk_seq("resume1", 1, '{3,1}, 0);

`ifdef ARB_STATS_EN
    // Five beats from req 1, then saturation from req 0.
    t_vld = '0;
    rstn = 1'b0;
    tick(1);
    rstn = 1'b1;
    t_vld = 4'b0010;
    tick(5);
    t_vld = '0;
    tick(2);
    for (int r = 0; r < N; r++) begin
      chk("stat5_0", 64'(st0[r*16 +: 16]), (r == 1) ? 64'd5 : 64'd0);
      chk("stat5_1", 64'(st1[r*16 +: 16]), (r == 1) ? 64'd5 : 64'd0);
    end
    t_vld = 4'b0001;
    tick(70000);
    t_vld = '0;
    tick(2);
    chk("stat_sat0", 64'(st0[15:0]), 64'hFFFF);
    chk("stat_sat1", 64'(st1[15:0]), 64'hFFFF);
    chk("stat_keep", 64'(st0[31:16]), 64'd5);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
